// File: rtl/window_pkg.sv
// Shared types for the window streamer: FSM states, pixel type, SIZE ceiling.
package window_pkg;

    localparam int MAX_SIZE = 8;

    typedef logic [7:0] pixel_t;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        STREAM,
        HOLD,
        DONE
    } state_e;

endpackage

// File: rtl/line_buffer.sv
// One image row of pixel storage: write and read share the same column address,
// so the read returns the byte stored one row earlier before it is overwritten.
module line_buffer
    import window_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  pixel_t        din_i,
    output pixel_t        dout_o
);

    // Contents need no reset: every location is written before it is read.
    pixel_t mem_q [DEPTH];

    assign dout_o = mem_q[addr_i];

    // Store the incoming byte at the current column.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[addr_i] <= din_i;
    end

endmodule

// File: rtl/window_streamer.sv
// Sliding SIZE x SIZE window generator over a raster pixel stream.
// Optional feature: define WINDOW_STREAMER_STALL_CNT_EN to add the stall_cnt
// output (HOLD cycles with win_ready low, saturating, cleared on start).
module window_streamer
    import window_pkg::*;
#(
    parameter int SIZE    = 3,
    parameter int IMG_W   = 64,
    parameter int IMG_H   = 64,
    parameter int COORD_W = 8
) (
    input  logic                             clk,
    input  logic                             n_rst,
    input  logic                             start,
    input  pixel_t                           pix_data,
    input  logic                             pix_valid,
    output logic                             pix_ready,
    output logic [SIZE-1:0][SIZE-1:0][7:0]   window,
    output logic                             win_valid,
    input  logic                             win_ready,
    output logic [COORD_W-1:0]               win_x,
    output logic [COORD_W-1:0]               win_y,
    output logic                             busy,
    output logic                             frame_done
`ifdef WINDOW_STREAMER_STALL_CNT_EN
    ,
    output logic [15:0]                      stall_cnt
`endif
);

    typedef logic [COORD_W-1:0] coord_t;

    localparam int     LB_AW   = $clog2(IMG_W);
    localparam coord_t X_LAST  = coord_t'(IMG_W - 1);
    localparam coord_t SZ_M1   = coord_t'(SIZE - 1);
    localparam coord_t LAST_WX = coord_t'(IMG_W - SIZE);
    localparam coord_t LAST_WY = coord_t'(IMG_H - SIZE);

    state_e state_q, state_d;
    coord_t x_q, y_q;
    coord_t win_x_q, win_y_q;
    logic [SIZE-1:0][SIZE-1:0][7:0] window_q;
    logic [SIZE-2:0][7:0] lb_rd;
    logic [SIZE-1:0][7:0] col_w;
    logic accept, at_win, last_win;

    assign accept   = pix_valid & pix_ready;
    // Only the first pixel satisfying this in FILL is (SIZE-1, SIZE-1).
    assign at_win   = (x_q >= SZ_M1) && (y_q >= SZ_M1);
    assign last_win = (win_x_q == LAST_WX) && (win_y_q == LAST_WY);

    // Line buffers form a chain: buffer k delays the stream by k+1 rows.
    for (genvar k = 0; k < SIZE - 1; k++) begin : g_lb
        pixel_t din;
        if (k == 0) begin : g_head
            assign din = pix_data;
        end else begin : g_tail
            assign din = lb_rd[k-1];
        end
        line_buffer #(.DEPTH(IMG_W), .AW(LB_AW)) u_lb (
            .clk_i  (clk),
            .we_i   (accept),
            .addr_i (x_q[LB_AW-1:0]),
            .din_i  (din),
            .dout_o (lb_rd[k])
        );
    end

    // New rightmost column: bottom row is the live pixel, upper rows from line buffers.
    always_comb begin
        col_w = '0;
        col_w[SIZE-1] = pix_data;
        for (int r = 0; r < SIZE - 1; r++) col_w[r] = lb_rd[SIZE-2-r];
    end

    // FSM state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and state-decoded handshake/status outputs.
    always_comb begin
        state_d    = state_q;
        pix_ready  = 1'b0;
        win_valid  = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) state_d = FILL;
            end
            FILL, STREAM: begin
                pix_ready = 1'b1;
                if (accept && at_win) state_d = HOLD;
                else                  state_d = STREAM;
                if (state_q == FILL && !(accept && at_win)) state_d = FILL;
            end
            HOLD: begin
                win_valid = 1'b1;
                if (win_ready) state_d = last_win ? DONE : STREAM;
            end
            DONE: begin
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            x_q <= '0;
            y_q <= '0;
        end else if (state_q == IDLE && start) begin
            x_q <= '0;
            y_q <= '0;
        end else if (accept) begin
            if (x_q == X_LAST) begin
                x_q <= '0;
                y_q <= y_q + coord_t'(1);
            end else begin
                x_q <= x_q + coord_t'(1);
            end
        end
    end

    // Latch the window origin when the completing pixel arrives.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            win_x_q <= '0;
            win_y_q <= '0;
        end else if (accept && at_win) begin
            win_x_q <= x_q - SZ_M1;
            win_y_q <= y_q - SZ_M1;
        end
    end

    // Shift the window left by one column on every accepted pixel.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            window_q <= '0;
        end else if (accept) begin
            for (int r = 0; r < SIZE; r++) begin
                for (int c = 0; c < SIZE - 1; c++) window_q[r][c] <= window_q[r][c+1];
                window_q[r][SIZE-1] <= col_w[r];
            end
        end
    end

    assign window = window_q;
    assign win_x  = win_x_q;
    assign win_y  = win_y_q;

`ifdef WINDOW_STREAMER_STALL_CNT_EN
    logic [15:0] stall_q;

    // Count back-pressured HOLD cycles, saturating; restart at each new frame.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)                                        stall_q <= '0;
        else if (state_q == IDLE && start)                 stall_q <= '0;
        else if (state_q == HOLD && !win_ready && stall_q != 16'hFFFF)
                                                           stall_q <= stall_q + 16'd1;
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_window_streamer.sv
// Self-checking bench: image-level window model plus a SIZE=2 corner instance.
module tb_window_streamer;

    localparam int S = 3, W = 5, H = 4;
    localparam int NWX = W - S + 1, NWY = H - S + 1, NW = NWX * NWY, NP = W * H;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic n_rst, start, pix_valid, pix_ready, win_valid, win_ready, busy, frame_done;
    logic [7:0] pix_data, win_x, win_y;
    logic [S-1:0][S-1:0][7:0] window;

    logic b_start, b_pix_valid, b_pix_ready, b_win_valid, b_win_ready, b_busy, b_frame_done;
    logic [7:0] b_pix_data, b_win_x, b_win_y;
    logic [1:0][1:0][7:0] b_window;
`ifdef WINDOW_STREAMER_STALL_CNT_EN
    logic [15:0] stall_cnt, b_stall_cnt;
`endif

    window_streamer #(.SIZE(S), .IMG_W(W), .IMG_H(H), .COORD_W(8)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .window(window), .win_valid(win_valid), .win_ready(win_ready),
        .win_x(win_x), .win_y(win_y), .busy(busy), .frame_done(frame_done)
`ifdef WINDOW_STREAMER_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    window_streamer #(.SIZE(2), .IMG_W(2), .IMG_H(2), .COORD_W(8)) dut_b (
        .clk(clk), .n_rst(n_rst), .start(b_start), .pix_data(b_pix_data), .pix_valid(b_pix_valid),
        .pix_ready(b_pix_ready), .window(b_window), .win_valid(b_win_valid), .win_ready(b_win_ready),
        .win_x(b_win_x), .win_y(b_win_y), .busy(b_busy), .frame_done(b_frame_done)
`ifdef WINDOW_STREAMER_STALL_CNT_EN
        , .stall_cnt(b_stall_cnt)
`endif
    );

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model state: the frame image and the index of the window the DUT should present next.
    logic [7:0] img [H][W];
    int win_idx, done_cnt = 0, pi;
    logic lit_mode = 1'b0;
    logic [S-1:0][S-1:0][7:0] lit0, exp_w;
    logic [1:0][1:0][7:0] lit1;
    int rdy_mode = 0, stall_n = 0;

    // Compare every presented window against the image: window k sits at (k%NWX, k/NWX).
    int cwx, cwy;
    always @(negedge clk) begin
        if (n_rst) begin
            if (frame_done) done_cnt++;
            if (win_valid) begin
                chk("win_idx_bound", 128'(win_idx < NW), 128'd1);
                if (win_idx < NW) begin
                    cwx = win_idx % NWX;
                    cwy = win_idx / NWX;
                    for (int r = 0; r < S; r++)
                        for (int c = 0; c < S; c++) exp_w[r][c] = img[cwy+r][cwx+c];
                    chk("window", 128'(window), 128'(exp_w));
                    chk("win_x", 128'(win_x), 128'(cwx));
                    chk("win_y", 128'(win_y), 128'(cwy));
                    chk("pix_ready_in_hold", 128'(pix_ready), 128'd0);
                    chk("busy_in_hold", 128'(busy), 128'd1);
                    if (lit_mode && win_idx == 0) chk("first_window_literal", 128'(window), 128'(lit0));
                end
                if (win_ready) win_idx++;
            end
        end
    end

    // win_ready: always high, random, or a 4-cycle stall on the second window.
    initial begin
        win_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                1: win_ready = 1'($urandom_range(0, 1));
                2: if (win_valid && win_idx == 1 && stall_n < 4) begin
                       win_ready = 1'b0;
                       stall_n++;
                   end else win_ready = 1'b1;
                default: win_ready = 1'b1;
            endcase
        end
    end

    task automatic run_frame(input bit pat, input bit rnd_valid, input int rmode,
                             input bit inj_start, input int abort_at);
        int d0, cyc;
        bit xfer, injected;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) img[y][x] = pat ? 8'(y * W + x) : 8'($urandom);
        lit_mode = pat;
        rdy_mode = rmode;
        stall_n  = 0;
        win_idx  = 0;
        pi       = 0;
        d0       = done_cnt;
        injected = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 0;
        while (pi < NP && cyc < 2000) begin
            pix_data  = img[pi / W][pi % W];
            pix_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            if (inj_start && !injected && pi == 15) begin
                start    = 1'b1;
                injected = 1;
            end
            @(negedge clk);
            xfer = pix_valid && pix_ready;
            @(posedge clk); #1;
            start = 1'b0;
            if (xfer) pi++;
            cyc++;
            if (abort_at > 0 && pi == abort_at) begin
                pix_valid = 1'b0;
                n_rst = 1'b0;
                #1;
                chk("abort_reset_outputs",
                    128'({win_valid, pix_ready, busy, frame_done, win_x, win_y, window}), 128'd0);
                return;
            end
        end
        pix_valid = 1'b0;
        chk("pixels_accepted", 128'(pi), 128'(NP));
        cyc = 0;
        while (done_cnt == d0 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
        chk("frame_done_pulses", 128'(done_cnt - d0), 128'd1);
        chk("window_count", 128'(win_idx), 128'(NW));
        chk("busy_after_done", 128'(busy), 128'd0);
`ifdef WINDOW_STREAMER_STALL_CNT_EN
        if (rmode == 2) chk("stall_cnt", 128'(stall_cnt), 128'd4);
`endif
        rdy_mode = 0;
    endtask

    // SIZE=2 2x2 instance: one window expected.
    int b_cnt = 0, b_done = 0;
    logic [1:0][1:0][7:0] b_last;
    logic [7:0] b_lx, b_ly;
    always @(negedge clk) begin
        if (n_rst) begin
            if (b_frame_done) b_done++;
            if (b_win_valid && b_win_ready) begin
                b_cnt++;
                b_last = b_window;
                b_lx   = b_win_x;
                b_ly   = b_win_y;
            end
        end
    end

    task automatic run_small();
        int bp, cyc;
        bit xfer;
        bp = 0;
        @(posedge clk); #1 b_start = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
        cyc = 0;
        while (bp < 4 && cyc < 100) begin
            b_pix_data  = 8'(bp + 1);
            b_pix_valid = 1'b1;
            @(negedge clk);
            xfer = b_pix_valid && b_pix_ready;
            @(posedge clk); #1;
            if (xfer) bp++;
            cyc++;
        end
        b_pix_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("small_pixels", 128'(bp), 128'd4);
        chk("small_win_count", 128'(b_cnt), 128'd1);
        chk("small_window", 128'(b_last), 128'(lit1));
        chk("small_win_xy", 128'({b_lx, b_ly}), 128'd0);
        chk("small_frame_done", 128'(b_done), 128'd1);
        chk("small_busy_after", 128'(b_busy), 128'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        lit0[0] = {8'd2, 8'd1, 8'd0};
        lit0[1] = {8'd7, 8'd6, 8'd5};
        lit0[2] = {8'd12, 8'd11, 8'd10};
        lit1[0] = {8'd2, 8'd1};
        lit1[1] = {8'd4, 8'd3};
        start = 1'b0; pix_valid = 1'b0; pix_data = 8'd0;
        b_start = 1'b0; b_pix_valid = 1'b0; b_pix_data = 8'd0; b_win_ready = 1'b1;
        n_rst = 1'b1;
        #2 n_rst = 1'b0;
        #3;
        chk("reset_outputs", 128'({win_valid, pix_ready, busy, frame_done, win_x, win_y, window}), 128'd0);
        chk("reset_outputs_b", 128'({b_win_valid, b_pix_ready, b_busy, b_frame_done, b_window}), 128'd0);
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;

        run_frame(1, 0, 0, 0, 0);   // pattern, no stalls
        run_frame(1, 0, 2, 0, 0);   // 4-cycle stall on window (1,0)
        run_frame(1, 0, 0, 1, 0);   // stray start mid-frame
        run_frame(1, 0, 0, 0, 9);   // reset after 9 pixels
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        repeat (2) @(posedge clk);
        chk("idle_after_abort", 128'({busy, pix_ready, win_valid}), 128'd0);
        run_frame(1, 0, 0, 0, 0);   // full frame after recovery
        run_frame(1, 1, 0, 0, 0);   // 50% pix_valid
        for (int i = 0; i < 3; i++) run_frame(0, 1, 1, 0, 0);  // random data and handshakes
        run_small();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/window_streamer.md
WINDOW_STREAMER -- requirements
Module: window_streamer

Interface
REQ-001 SHALL have parameter SIZE, default 4'd3, giving the window edge length in pixels (legal range 2..8).
REQ-002 SHALL have parameter IMG_W, default 64, giving the image width in pixels (must be at least SIZE).
REQ-003 SHALL have parameter IMG_H, default 64, giving the image height in pixels (must be at least SIZE).
REQ-004 SHALL have parameter COORD_W, default 8, giving the coordinate width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port n_rst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port start, input, 1 bit: one-cycle pulse that begins a frame.
REQ-008 SHALL have ports pix_data (input, 8 bits), pix_valid (input, 1 bit) and pix_ready (output, 1 bit): the raster-order pixel stream with valid/ready handshake.
REQ-009 SHALL have port window, output, [SIZE-1:0][SIZE-1:0][7:0]: window[r][c], r=0 is the top row, c=0 is the left column.
REQ-010 SHALL have ports win_valid (output, 1 bit) and win_ready (input, 1 bit): the window handshake toward the accumulator.
REQ-011 SHALL have ports win_x and win_y, output, COORD_W bits each: image coordinates of the window's top-left pixel.
REQ-012 SHALL have ports busy (output, 1 bit) and frame_done (output, 1 bit), where frame_done is a one-cycle pulse.

Function
REQ-013 SHALL implement FSM states IDLE, FILL, STREAM, HOLD and DONE.
REQ-014 IDLE SHALL move to FILL on start; start SHALL be ignored in every state other than IDLE.
REQ-015 A pixel transfer SHALL occur only when pix_valid and pix_ready are both high; pixels SHALL arrive in raster order with x increasing, wrapping at IMG_W-1 and incrementing y.
REQ-016 FILL SHALL accept pixels until pixel (SIZE-1, SIZE-1) is accepted, then move to HOLD.
REQ-017 In STREAM, accepting pixel (x,y) with x>=SIZE-1 and y>=SIZE-1 SHALL move to HOLD; accepting any other pixel SHALL keep the FSM in STREAM (edge pixels produce no window).
REQ-018 win_valid SHALL assert exactly one cycle after the completing pixel is accepted, with window, win_x=x-SIZE+1 and win_y=y-SIZE+1, all stable until win_ready is sampled high.
REQ-019 pix_ready SHALL be high only in FILL and STREAM; it SHALL be low in HOLD, IDLE and DONE.
REQ-020 HOLD with win_ready high SHALL move to STREAM, or to DONE if the window was the last one, i.e. (IMG_W-SIZE, IMG_H-SIZE).
REQ-021 DONE SHALL pulse frame_done for one cycle and return to IDLE.
REQ-022 A frame SHALL produce exactly (IMG_W-SIZE+1)*(IMG_H-SIZE+1) windows.
REQ-023 Line storage SHALL hold SIZE-1 previous rows of IMG_W bytes each, with the column address wrapping at IMG_W-1.
REQ-024 busy SHALL be high in every state except IDLE.

Reset
REQ-025 On n_rst low, the block SHALL asynchronously enter IDLE and clear the x/y counters, win_valid, pix_ready, frame_done, busy, win_x, win_y and window to 0.
REQ-026 Line-buffer contents SHALL need no reset, because FILL overwrites them before use.
REQ-027 Reset asserted mid-frame SHALL abandon the frame; the next frame SHALL begin only on a new start.

Configuration
REQ-028 The macro WINDOW_STREAMER_STALL_CNT_EN, when defined, SHALL add output stall_cnt[15:0], which counts cycles spent in HOLD with win_ready low, saturates at 16'hFFFF, and clears on start.
REQ-029 When WINDOW_STREAMER_STALL_CNT_EN is undefined, the stall_cnt port and its logic SHALL be absent, with no other behaviour change.

Structure
REQ-030 Package window_pkg SHALL hold the FSM state enum, the pixel_t typedef (8-bit) and the maximum-SIZE constant.
REQ-031 Sub-module line_buffer SHALL be a single-port-write / same-address-read row store of IMG_W bytes, instantiated SIZE-1 times.
REQ-032 The window shift registers and the FSM SHALL reside in window_streamer.

Verification
REQ-033 With SIZE=3, IMG_W=5, IMG_H=4 and pixel value y*5+x, streamed with no stalls, the first window SHALL be rows {0,1,2},{5,6,7},{10,11,12} at (0,0), and six windows SHALL follow in order (0,0),(1,0),(2,0),(0,1),(1,1),(2,1), then frame_done.
REQ-034 Holding win_ready low for 4 cycles on window (1,0) SHALL hold win_valid and window stable and keep pix_ready low, with no pixel lost; the stall counter (macro defined) SHALL read 4.
REQ-035 Pulsing start during STREAM SHALL leave the window sequence and count unchanged.
REQ-036 Asserting n_rst low at pixel 9 SHALL zero all outputs immediately; a new start plus a full frame SHALL then reproduce REQ-033 exactly.
REQ-037 Pulsing pix_valid at random 50% duty with win_ready always high SHALL produce window contents identical to REQ-033.
REQ-038 With SIZE=2, IMG_W=IMG_H=2 and pixels 1,2,3,4, exactly one window {1,2},{3,4} at (0,0) SHALL be produced, followed by a frame_done pulse.
